frame_assembler: RTL and testbench

Receive-side stage directly upstream of the decoder. Collects a byte-wide channel stream from the transmission block into 128-bit codeword frames, delimited by a start-of-frame flag, and hands each complete frame to the decoder's `received_message` input over a valid/ready handshake. Double-buffered: one frame is held for the decoder while the next is assembled. Malformed or aborted frames are dropped and counted.

---
 rtl/frame_pkg.sv | 16 +
 rtl/frame_timeout_timer.sv | 29 ++
 rtl/frame_assembler.sv | 129 ++++++++++++
 tb/tb_frame_assembler.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/frame_pkg.sv
// Shared constants and types for the receive-side frame assembly path.
package frame_pkg;

  localparam int unsigned FRAME_BYTES = 16;
  localparam int unsigned FRAME_W     = FRAME_BYTES * 8;
  localparam int unsigned IDX_W       = $clog2(FRAME_BYTES);

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    STALL
  } asm_state_t;

  typedef logic [IDX_W-1:0] byte_idx_t;

endpackage

// File: rtl/frame_timeout_timer.sv
// Idle-gap counter for a partially assembled frame.
// expired asserts on the TIMEOUT_CYCLES-th consecutive enabled cycle.
module frame_timeout_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] cnt_q;

  assign expired = enable && (cnt_q == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (enable && !expired) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/frame_assembler.sv
// Collects sof-delimited byte runs into 128-bit frames for the decoder, double-buffered.
// Optional idle-gap abort inside a frame: define FRAME_TIMEOUT_EN.
module frame_assembler #(
  parameter int unsigned FRAME_BYTES    = 16,
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter int unsigned CNT_W          = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [7:0]               rx_byte,
  input  logic                     rx_valid,
  input  logic                     rx_sof,
  output logic                     rx_ready,
  output logic [FRAME_BYTES*8-1:0] frame_out,
  output logic                     frame_valid,
  input  logic                     frame_ready,
  output logic [CNT_W-1:0]         drop_cnt,
  output logic                     busy
);

  import frame_pkg::*;

  localparam int unsigned FW       = FRAME_BYTES * 8;
  localparam byte_idx_t   LAST_IDX = byte_idx_t'(FRAME_BYTES - 1);

  asm_state_t    state_q, state_d;
  byte_idx_t     idx_q, idx_d;
  logic [FW-1:0] asm_q, asm_d, shifted, xfer_data;
  logic          accept, out_free, load_out, drop, timeout_hit;

  assign rx_ready = (state_q != STALL);
  assign busy     = (state_q != IDLE);
  assign accept   = rx_valid && rx_ready;
  assign out_free = !frame_valid || frame_ready;
  assign shifted  = {asm_q[FW-9:0], rx_byte};

`ifdef FRAME_TIMEOUT_EN
  frame_timeout_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  (accept || (state_q != COLLECT)),
    .enable ((state_q == COLLECT) && !accept),
    .expired(timeout_hit)
  );
`else
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    asm_d     = asm_q;
    xfer_data = asm_q;
    load_out  = 1'b0;
    drop      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if (rx_sof) begin
            asm_d   = shifted;
            idx_d   = byte_idx_t'(1);
            state_d = COLLECT;
          end else begin
            drop = 1'b1;
          end
        end
      end
      COLLECT: begin
        if (accept) begin
          asm_d     = shifted;
          xfer_data = shifted;
          if (rx_sof) begin
            // Restart on the new sof byte; older bytes shift out before completion.
            drop  = 1'b1;
            idx_d = byte_idx_t'(1);
          end else if (idx_q == LAST_IDX) begin
            idx_d = '0;
            if (out_free) begin
              load_out = 1'b1;
              state_d  = IDLE;
            end else begin
              state_d = STALL;
            end
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end else if (timeout_hit) begin
          drop    = 1'b1;
          idx_d   = '0;
          state_d = IDLE;
        end
      end
      STALL: begin
        if (frame_ready) begin
          load_out = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      asm_q       <= '0;
      frame_out   <= '0;
      frame_valid <= 1'b0;
      drop_cnt    <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      asm_q   <= asm_d;
      if (load_out) begin
        frame_out   <= xfer_data;
        frame_valid <= 1'b1;
      end else if (frame_ready) begin
        frame_valid <= 1'b0;
      end
      if (drop && (drop_cnt != '1)) begin
        drop_cnt <= drop_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_frame_assembler.sv
// Directed bench for frame_assembler with a frame scoreboard checked at each handshake.
module tb_frame_assembler;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [7:0]   rx_byte;
  logic         rx_valid;
  logic         rx_sof;
  logic         rx_ready;
  logic [127:0] frame_out;
  logic         frame_valid;
  logic         frame_ready;
  logic [7:0]   drop_cnt;
  logic         busy;

  int checks   = 0;
  int failures = 0;
  int delivered = 0;
  int expected_delivered = 0;
  int wait_total = 0;
  logic [127:0] exp_q[$];

  always #5 clk = ~clk;

  frame_assembler #(
    .FRAME_BYTES(16),
    .TIMEOUT_CYCLES(64),
    .CNT_W(8)
  ) dut (
    .clk        (clk),
    .rst        (rst_n),
    .rx_byte    (rx_byte),
    .rx_valid   (rx_valid),
    .rx_sof     (rx_sof),
    .rx_ready   (rx_ready),
    .frame_out  (frame_out),
    .frame_valid(frame_valid),
    .frame_ready(frame_ready),
    .drop_cnt   (drop_cnt),
    .busy       (busy)
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] mk_frame(input logic [7:0] base);
    logic [127:0] f;
    f = '0;
    for (int unsigned i = 0; i < 16; i++) f = {f[119:0], base + 8'(i)};
    return f;
  endfunction

  // Scoreboard: every decoder handshake must match the oldest expected frame.
  always @(negedge clk) begin
    if (rst_n && frame_valid && frame_ready) begin
      checks++;
      assert (exp_q.size() > 0) else begin
        failures++;
        $error("FAIL unexpected_frame observed=%h expected=none", frame_out);
      end
      if (exp_q.size() > 0) begin
        check("frame_data", frame_out, exp_q.pop_front());
        delivered++;
      end
    end
  end

  task automatic send(input logic [7:0] b, input logic sof);
    int n;
    rx_byte  = b;
    rx_sof   = sof;
    rx_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!rx_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    wait_total += n;
    checks++;
    assert (n < 200) else begin
      failures++;
      $error("FAIL send_timeout observed=%0d expected<200", n);
    end
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
    rx_sof   = 1'b0;
  endtask

  task automatic send_bytes(input logic [7:0] base, input int unsigned first, input int unsigned count);
    for (int unsigned i = first; i < first + count; i++) send(base + 8'(i), i == 0);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("rst_frame_out", frame_out, 128'h0);
    check("rst_frame_valid", frame_valid, 0);
    check("rst_drop_cnt", drop_cnt, 0);
    check("rst_busy", busy, 0);
    check("rst_rx_ready", rx_ready, 1);
    exp_q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    rx_byte = '0;
    rx_valid = 1'b0;
    rx_sof = 1'b0;
    frame_ready = 1'b1;
    #1;
    check("init_frame_valid", frame_valid, 0);
    check("init_busy", busy, 0);
    check("init_rx_ready", rx_ready, 1);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Basic frame 0x00..0x0F, one-cycle valid pulse.
    exp_q.push_back(mk_frame(8'h00));
    expected_delivered++;
    send_bytes(8'h00, 0, 16);
    check("t1_valid", frame_valid, 1);
    check("t1_data", frame_out, 128'h000102030405060708090A0B0C0D0E0F);
    @(posedge clk);
    #1;
    check("t1_valid_fall", frame_valid, 0);
    check("t1_drop", drop_cnt, 0);
    check("t1_busy", busy, 0);

    // Three stray bytes in IDLE, then a good frame.
    do_reset();
    send(8'hAA, 1'b0);
    send(8'hBB, 1'b0);
    send(8'hCC, 1'b0);
    check("t2_drop", drop_cnt, 3);
    exp_q.push_back(mk_frame(8'h10));
    expected_delivered++;
    send_bytes(8'h10, 0, 16);
    @(posedge clk);
    #1;
    check("t2_drop_after", drop_cnt, 3);

    // Early sof restarts the frame.
    do_reset();
    send_bytes(8'h50, 0, 5);
    check("t3_busy_partial", busy, 1);
    exp_q.push_back(mk_frame(8'h60));
    expected_delivered++;
    send_bytes(8'h60, 0, 16);
    check("t3_drop", drop_cnt, 1);
    @(posedge clk);
    #1;

    // Back-to-back frames with frame_ready high never stall the input.
    do_reset();
    wait_total = 0;
    exp_q.push_back(mk_frame(8'h70));
    exp_q.push_back(mk_frame(8'h80));
    expected_delivered += 2;
    send_bytes(8'h70, 0, 16);
    send_bytes(8'h80, 0, 16);
    check("t4_no_stall", wait_total, 0);
    @(posedge clk);
    #1;

    // Held frame plus a second frame forces STALL.
    do_reset();
    frame_ready = 1'b0;
    exp_q.push_back(mk_frame(8'h20));
    exp_q.push_back(mk_frame(8'h40));
    expected_delivered += 2;
    send_bytes(8'h20, 0, 16);
    send_bytes(8'h40, 0, 16);
    check("t5_rx_ready_stall", rx_ready, 0);
    check("t5_busy_stall", busy, 1);
    check("t5_held_valid", frame_valid, 1);
    check("t5_held_data", frame_out, mk_frame(8'h20));
    frame_ready = 1'b1;
    @(posedge clk);
    #1;
    frame_ready = 1'b0;
    check("t5_second_valid", frame_valid, 1);
    check("t5_second_data", frame_out, mk_frame(8'h40));
    check("t5_rx_ready_back", rx_ready, 1);
    check("t5_busy_idle", busy, 0);
    @(posedge clk);
    #1;
    check("t5_stable_data", frame_out, mk_frame(8'h40));
    frame_ready = 1'b1;
    @(posedge clk);
    #1;
    check("t5_drained", frame_valid, 0);

`ifdef FRAME_TIMEOUT_EN
    // 64-cycle gap aborts; 63-cycle gap does not.
    do_reset();
    send_bytes(8'h90, 0, 4);
    repeat (63) @(posedge clk);
    #1;
    check("t6_busy_63", busy, 1);
    @(posedge clk);
    #1;
    check("t6_busy_64", busy, 0);
    check("t6_drop_64", drop_cnt, 1);
    exp_q.push_back(mk_frame(8'hA0));
    expected_delivered++;
    send_bytes(8'hA0, 0, 4);
    repeat (63) @(posedge clk);
    #1;
    send_bytes(8'hA0, 4, 12);
    @(posedge clk);
    #1;
    check("t6_drop_after", drop_cnt, 1);
`else
    // Without the timer a partial frame waits indefinitely.
    do_reset();
    send_bytes(8'h90, 0, 4);
    repeat (100) @(posedge clk);
    #1;
    check("t6_busy_wait", busy, 1);
    check("t6_drop_wait", drop_cnt, 0);
    exp_q.push_back(mk_frame(8'h90));
    expected_delivered++;
    send_bytes(8'h90, 4, 12);
    @(posedge clk);
    #1;
    check("t6_drop_after", drop_cnt, 0);
`endif

    // Reset mid-frame with a held frame: both lost, nothing counted.
    do_reset();
    frame_ready = 1'b0;
    send_bytes(8'hC0, 0, 16);
    send_bytes(8'hD0, 0, 8);
    check("t7_held_before", frame_valid, 1);
    do_reset();
    frame_ready = 1'b1;
    exp_q.push_back(mk_frame(8'hE0));
    expected_delivered++;
    send_bytes(8'hE0, 0, 16);
    check("t7_data", frame_out, mk_frame(8'hE0));
    @(posedge clk);
    #1;
    check("t7_drop", drop_cnt, 0);

    repeat (3) @(posedge clk);
    #1;
    check("sb_empty", exp_q.size(), 0);
    check("sb_delivered", delivered, expected_delivered);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
